// File: rtl/memoire_pkg.sv
// Shared definitions for the save memory and its manager:
// state encoding, default widths and RW direction encoding.
package memoire_pkg;

    localparam int ADDR_W_DEF = 7;
    localparam int DATA_W_DEF = 7;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [1:0] {
        ST_CLEAR  = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

endpackage

// File: rtl/mem_array_sp.sv
// Single-port storage array: synchronous write, registered read.
// Storage and read register are deliberately left without reset.
module mem_array_sp #(
    parameter int AW    = 7,
    parameter int DW    = 7,
    parameter int DEPTH = 2**AW
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic          i_re,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_wdata,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];

    // Write port
    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_addr] <= i_wdata;
    end

    // Read port, holds last read word when not enabled
    always_ff @(posedge i_clk) begin
        if (i_re) o_rdata <= r_mem[i_addr];
    end

endmodule

// File: rtl/memoire_sauvegarde.sv
// Latch-strobed save memory serving the save-memory manager.
// Macro MEM_SAUVEGARDE_CLEAR_EN enables the post-reset clear sweep.
module memoire_sauvegarde
    import memoire_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic [ADDR_W-1:0] AddOut,
    input  logic [DATA_W-1:0] DataBusIn,
    input  logic              RW,
    input  logic              Latch,
    output logic [DATA_W-1:0] DataBusOut,
    output logic              Busy,
    output logic              Err
);

    state_t              r_state;
    state_t              w_next;
    logic                r_latch_q;
    logic [ADDR_W-1:0]   r_add_q;
    logic                r_rw_q;
    logic [DATA_W-1:0]   r_dat_q;
    logic                r_err;
    logic [DATA_W-1:0]   r_dout;
    logic                r_show_rd;
    logic                w_strobe;
    logic                w_capture;
    logic                w_we;
    logic                w_re;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_wdata;
    logic [DATA_W-1:0]   w_rdata;
`ifdef MEM_SAUVEGARDE_CLEAR_EN
    logic [ADDR_W-1:0]   r_clr_addr;
`endif

    assign w_strobe = Latch & ~r_latch_q;

`ifdef MEM_SAUVEGARDE_CLEAR_EN
    assign Busy = (r_state == ST_CLEAR);
`else
    assign Busy = 1'b0;
`endif

    // Reads show the array port directly; writes show the latched data
    assign DataBusOut = r_show_rd ? w_rdata : r_dout;
    assign Err        = r_err;

    // State register
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
`ifdef MEM_SAUVEGARDE_CLEAR_EN
            r_state <= ST_CLEAR;
`else
            r_state <= ST_IDLE;
`endif
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and array control
    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        w_we      = 1'b0;
        w_re      = 1'b0;
        w_addr    = r_add_q;
        w_wdata   = r_dat_q;
        unique case (r_state)
`ifdef MEM_SAUVEGARDE_CLEAR_EN
            ST_CLEAR: begin
                w_we    = 1'b1;
                w_addr  = r_clr_addr;
                w_wdata = '0;
                if (r_clr_addr == ADDR_W'(DEPTH - 1)) w_next = ST_IDLE;
            end
`endif
            ST_IDLE: begin
                if (w_strobe) begin
                    w_capture = 1'b1;
                    w_next    = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                w_next = ST_IDLE;
                if (r_rw_q == RW_READ) w_re = 1'b1;
                else                   w_we = 1'b1;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Edge detect, capture registers, output register and error flag
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_latch_q <= 1'b0;
            r_add_q   <= '0;
            r_rw_q    <= 1'b0;
            r_dat_q   <= '0;
            r_err     <= 1'b0;
            r_dout    <= '0;
            r_show_rd <= 1'b0;
        end else begin
            r_latch_q <= Latch;
            if (w_strobe && Busy) r_err <= 1'b1;
            if (w_capture) begin
                r_add_q <= AddOut;
                r_rw_q  <= RW;
                r_dat_q <= DataBusIn;
            end
            if (r_state == ST_ACCESS) begin
                if (r_rw_q == RW_READ) begin
                    r_show_rd <= 1'b1;
                end else begin
                    r_show_rd <= 1'b0;
                    r_dout    <= r_dat_q;
                end
            end
        end
    end

`ifdef MEM_SAUVEGARDE_CLEAR_EN
    // Clear sweep address, restarts from zero on every reset
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)                 r_clr_addr <= '0;
        else if (r_state == ST_CLEAR) r_clr_addr <= r_clr_addr + 1'b1;
    end
`endif

    mem_array_sp #(
        .AW    (ADDR_W),
        .DW    (DATA_W),
        .DEPTH (DEPTH)
    ) u_array (
        .i_clk   (Clk),
        .i_we    (w_we),
        .i_re    (w_re),
        .i_addr  (w_addr),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata)
    );

endmodule

// File: tb/tb_memoire_sauvegarde.sv
// Bench for memoire_sauvegarde: manager-paced accesses against a
// word-level memory model; clear tests under MEM_SAUVEGARDE_CLEAR_EN.
module tb_memoire_sauvegarde;

    logic       Clk;
    logic       Rst_n;
    logic [6:0] AddOut;
    logic [6:0] DataBusIn;
    logic       RW;
    logic       Latch;
    logic [6:0] DataBusOut;
    logic       Busy;
    logic       Err;

    int checks = 0;
    int errors = 0;

    logic [6:0] mem_m [int];
    logic [6:0] exp_dout;
    logic       exp_known;
    logic       exp_err;
    int         cnt;

    memoire_sauvegarde dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .AddOut     (AddOut),
        .DataBusIn  (DataBusIn),
        .RW         (RW),
        .Latch      (Latch),
        .DataBusOut (DataBusOut),
        .Busy       (Busy),
        .Err        (Err)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    function automatic logic exp_busy();
`ifdef MEM_SAUVEGARDE_CLEAR_EN
        return (cnt < 128);
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string nm, input logic [6:0] act,
                       input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Rising edges since reset release
    always @(posedge Clk) begin
        if (Rst_n && cnt < 1000) cnt = cnt + 1;
    end

    // Continuous comparison against the model, half a cycle after each edge
    always @(negedge Clk) begin
        #1;
        chk("busy", {6'd0, Busy}, {6'd0, exp_busy()});
        chk("err", {6'd0, Err}, {6'd0, exp_err});
        if (exp_known) chk("dout", DataBusOut, exp_dout);
    end

    task automatic model_reset();
        exp_dout  = '0;
        exp_known = 1'b1;
        exp_err   = 1'b0;
        cnt       = 0;
        mem_m.delete();
`ifdef MEM_SAUVEGARDE_CLEAR_EN
        for (int a = 0; a < 128; a++) mem_m[a] = '0;
`endif
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Rst_n = 1'b0;
        Latch = 1'b0;
        model_reset();
        repeat (2) @(negedge Clk);
        Rst_n = 1'b1;
    endtask

    task automatic wait_clear();
`ifdef MEM_SAUVEGARDE_CLEAR_EN
        for (int i = 0; i < 300 && cnt < 128; i++) @(negedge Clk);
`endif
    endtask

    // Manager-paced access: raise, drop, sample on consecutive falling edges
    task automatic access(input logic rw, input logic [6:0] a,
                          input logic [6:0] d);
        logic b;
        @(negedge Clk);
        AddOut    = a;
        DataBusIn = d;
        RW        = rw;
        Latch     = 1'b1;
        b         = exp_busy();
        @(negedge Clk);
        Latch = 1'b0;
        if (b) exp_err = 1'b1;
        @(negedge Clk);
        if (!b) begin
            if (rw == 1'b0) begin
                mem_m[int'(a)] = d;
                exp_dout  = d;
                exp_known = 1'b1;
            end else if (mem_m.exists(int'(a))) begin
                exp_dout  = mem_m[int'(a)];
                exp_known = 1'b1;
            end else begin
                exp_known = 1'b0;
            end
        end
        #2;
    endtask

    initial begin
        logic [6:0] d;
        logic [6:0] a;
        Rst_n     = 1'b0;
        Latch     = 1'b0;
        RW        = 1'b1;
        AddOut    = '0;
        DataBusIn = '0;
        model_reset();
        #1;
        chk("rst_dout", DataBusOut, 7'h00);
        chk("rst_err", {6'd0, Err}, 7'h00);
        do_reset();

`ifdef MEM_SAUVEGARDE_CLEAR_EN
        for (int i = 0; i < 200 && cnt < 9; i++) @(negedge Clk);
        access(1'b0, 7'h7F, 7'h3C);
        chk("err_set", {6'd0, Err}, 7'h01);
        chk("busy_mid", {6'd0, Busy}, 7'h01);
        wait_clear();
        #2;
        chk("busy_done", {6'd0, Busy}, 7'h00);
        access(1'b1, 7'h7F, 7'h00);
        chk("clr_7f", DataBusOut, 7'h00);
`endif

        access(1'b0, 7'h13, 7'h0F);
        access(1'b0, 7'h12, 7'h55);
        chk("wr_55", DataBusOut, 7'h55);
        access(1'b1, 7'h12, 7'h00);
        chk("rd_12", DataBusOut, 7'h55);
        access(1'b1, 7'h13, 7'h00);
        chk("rd_13", DataBusOut, 7'h0F);

        // Latch held high for five cycles: only one write of the first data
        @(negedge Clk);
        AddOut    = 7'h20;
        DataBusIn = 7'h11;
        RW        = 1'b0;
        Latch     = 1'b1;
        repeat (2) @(negedge Clk);
        mem_m[32] = 7'h11;
        exp_dout  = 7'h11;
        exp_known = 1'b1;
        DataBusIn = 7'h22;
        repeat (3) @(negedge Clk);
        Latch = 1'b0;
        access(1'b1, 7'h20, 7'h00);
        chk("held_20", DataBusOut, 7'h11);

        // Write then read every address
        for (int i = 0; i < 128; i++) begin
            a = 7'(i);
            access(1'b0, a, a ^ 7'h2A);
        end
        for (int i = 0; i < 128; i++) begin
            a = 7'(i);
            access(1'b1, a, 7'h00);
            chk("sweep", DataBusOut, a ^ 7'h2A);
        end

        // Random traffic with random idle gaps
        for (int i = 0; i < 300; i++) begin
            a = 7'($urandom_range(0, 127));
            d = 7'($urandom);
            access(1'($urandom), a, d);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge Clk);
        end

        // Reset asserted during the access cycle of a write
        @(negedge Clk);
        AddOut    = 7'h05;
        DataBusIn = 7'h7F;
        RW        = 1'b0;
        Latch     = 1'b1;
        @(negedge Clk);
        Latch = 1'b0;
        Rst_n = 1'b0;
        model_reset();
        #1;
        chk("abort_dout", DataBusOut, 7'h00);
        chk("abort_err", {6'd0, Err}, 7'h00);
        repeat (2) @(negedge Clk);
        Rst_n = 1'b1;
        wait_clear();
        access(1'b1, 7'h05, 7'h00);
`ifdef MEM_SAUVEGARDE_CLEAR_EN
        chk("abort_rd05", DataBusOut, 7'h00);
`endif
        access(1'b0, 7'h05, 7'h6B);
        chk("post_wr05", DataBusOut, 7'h6B);
        access(1'b1, 7'h05, 7'h00);
        chk("post_rd05", DataBusOut, 7'h6B);

        repeat (2) @(negedge Clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/memoire_sauvegarde.md
# memoire_sauvegarde

Synchronous single-port save memory that sits directly downstream of the save-memory manager and serves its latch-strobed bus. A rising edge on `Latch` captures address, direction and write data. The block then performs one read or write into a 128 x 7 array and drives the result on `DataBusOut` in time for the manager's print step. An optional power-up clear sweep zeroes the array after reset.

## Interface
- `ADDR_W`, default 7: address width.
- `DATA_W`, default 7: data width.
- `DEPTH`, default 2**ADDR_W: number of words (128).

- `Clk`  in  1: single clock; all state updates on rising edge.
- `Rst_n`  in  1: reset, asynchronous assert, active-low.
- `AddOut`  in  ADDR_W: access address from the manager.
- `DataBusIn`  in  DATA_W: write data from the manager.
- `RW`  in  1: direction, 1 = read, 0 = write; sampled with `Latch`.
- `Latch`  in  1: access strobe; the rising edge starts an access.
- `DataBusOut`  out  DATA_W: read data, or write-through data after a write.
- `Busy`  out  1: array unavailable (clear sweep in progress).
- `Err`  out  1: sticky flag; a strobe arrived while `Busy`.

## Operation
- Edge detect: `Latch_q` is a register of `Latch`. A strobe is `Latch & ~Latch_q`, evaluated each rising `Clk`.
- FSM states: CLEAR, IDLE, ACCESS.
- CLEAR (only with macro):
  - Counter `ClrAddr` walks 0..DEPTH-1, writing 0 to one word per cycle.
  - After the write at DEPTH-1 → IDLE. `Busy`=1 throughout.
- IDLE:
  - On strobe, capture `AddOut`, `RW` and `DataBusIn` into `AddQ`, `RwQ` and `DatQ`, then → ACCESS.
  - No strobe → stay.
- ACCESS (exactly one cycle, then → IDLE):
  - `RwQ`=1: `DataBusOut` ← mem[`AddQ`].
  - `RwQ`=0: mem[`AddQ`] ← `DatQ` and `DataBusOut` ← `DatQ`.
- Strobe during ACCESS: ignored. `Err` is not set, because the manager cannot legally issue one.
- Strobe during CLEAR: ignored, `Err` ← 1. `Err` clears only on reset.
- `Latch` held high: one access only; a new access requires `Latch` to return low.
- `DataBusOut` holds its value between accesses.
- Address is full-width; no out-of-range case exists (`DEPTH` = 2**`ADDR_W`).

## Timing
- Reset values:
  - `DataBusOut`=0, `Err`=0, `Latch_q`=0, `AddQ`/`RwQ`/`DatQ`=0, `ClrAddr`=0.
  - State = CLEAR and `Busy`=1 with the macro; state = IDLE and `Busy`=0 without.
- Latency: strobe sampled at rising edge k → `DataBusOut` valid after rising edge k+1.
  - The manager raises `Latch` on a falling edge, drops it one falling edge later, and samples `DataBusOut` on the next falling edge. That sample lands half a cycle after edge k+1, so the data is stable when read.
- Write visibility: a read strobed at edge k+2 or later returns the data written by an access at edge k+1.
- Clear duration: DEPTH cycles after reset release, so `Busy` falls after rising edge DEPTH.
- Reset mid-operation:
  - An access in flight is aborted and the array write is suppressed.
  - With the macro, the clear sweep restarts from address 0.

## Configuration
- Macro `MEM_SAUVEGARDE_CLEAR_EN`.
- Defined:
  - CLEAR state and `ClrAddr` counter are present.
  - Array is zeroed after every reset.
  - `Busy` is high for DEPTH cycles after reset.
- Undefined:
  - No CLEAR state.
  - Array contents after reset are undefined (simulation X).
  - `Busy` is tied to 0, so `Err` never sets.

## Structure
- Shared package `memoire_pkg`:
  - State encoding constants (CLEAR, IDLE, ACCESS).
  - Default `ADDR_W`/`DATA_W`.
  - RW encoding constants (READ=1, WRITE=0), shared with the manager.
- Sub-module `mem_array_sp`:
  - Parameterised single-port array, one synchronous write port, one read port registered on `Clk`.
  - No reset on storage.
  - The top level holds the edge detect, FSM, capture registers, clear counter and flags.

## Test plan
- Macro defined: release reset → `Busy`=1 for 128 cycles, then 0. Read address 0x7F → `DataBusOut`=0x00.
- Write 0x55 to address 0x12: `DataBusOut`=0x55 one cycle after the strobe. A following read of 0x12 → 0x55. A read of 0x13 is unchanged.
- `Latch` held high for 5 cycles with RW=0, address 0x20, data 0x11: exactly one write occurs. Change the data to 0x22 while `Latch` is still high, then read 0x20 → 0x11.
- Strobe issued at cycle 10 during the clear sweep: no array change, `Err`=1 and it stays 1 until `Rst_n` is asserted.
- Assert `Rst_n` low in the ACCESS cycle of a write of 0x7F to 0x05: `DataBusOut`=0 immediately. After the clear, read 0x05 → 0x00.
- Back-to-back: manager-paced write then read of all 128 addresses with data = address XOR 0x2A → every read matches.
